// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and helpers for the ADC decimator
package adc_pkg;

  localparam int ADC_AXIS_WIDTH = 32;
  localparam int ADC_DATA_WIDTH = 24;

  typedef enum logic {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } decim_state_t;

  function automatic logic [3:0] clamp_log2_ratio(input logic [3:0] req,
                                                  input logic [3:0] max_r);
    return (req > max_r) ? max_r : req;
  endfunction

endpackage

// File: rtl/adc_decimator.sv
// rtl/adc_decimator.sv - power-of-two boxcar decimator on an AXI-Stream sample path
// Define ADC_DECIM_ROUND_EN for round-half-up results instead of truncation.
module adc_decimator
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH     = ADC_DATA_WIDTH,
  parameter int MAX_LOG2_RATIO = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [3:0]                log2_ratio,
  input  logic                      flush,
  input  logic [ADC_AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [ADC_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [15:0]               blocks_out
);

`ifdef ADC_DECIM_ROUND_EN
  localparam int ACC_W = DATA_WIDTH + MAX_LOG2_RATIO + 1;
`else
  localparam int ACC_W = DATA_WIDTH + MAX_LOG2_RATIO;
`endif
  localparam int         CNT_W = MAX_LOG2_RATIO + 1;
  localparam logic [3:0] MAX_R = 4'(MAX_LOG2_RATIO);

  decim_state_t               state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [3:0]                 r_cur_q, r_cur_d;
  logic                       tvalid_q, tvalid_d;
  logic [ADC_AXIS_WIDTH-1:0]  tdata_q, tdata_d;
  logic [15:0]                blocks_q, blocks_d;

  logic                       accept;
  logic [3:0]                 r_use;
  logic signed [ACC_W-1:0]    sample_ext;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [ACC_W-1:0]    rounded;
  logic signed [ACC_W-1:0]    shifted;
  logic [CNT_W-1:0]           cnt_sum;
  logic [CNT_W-1:0]           target;
  logic                       block_done;
  logic [ADC_AXIS_WIDTH-1:0]  result;
  logic                       unused_bits;

  assign s_axis_tready = !tvalid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign blocks_out    = blocks_q;

  assign unused_bits = ^{s_axis_tdata[ADC_AXIS_WIDTH-1:DATA_WIDTH],
                         shifted[ACC_W-1:DATA_WIDTH]};

  // Datapath for the sample being accepted this cycle; r_cur is only sampled on a block's first sample.
  always_comb begin
    sample_ext = {{(ACC_W-DATA_WIDTH){s_axis_tdata[DATA_WIDTH-1]}},
                  s_axis_tdata[DATA_WIDTH-1:0]};
    if (state_q == EMPTY) begin
      r_use   = clamp_log2_ratio(log2_ratio, MAX_R);
      acc_sum = sample_ext;
      cnt_sum = CNT_W'(1);
    end else begin
      r_use   = r_cur_q;
      acc_sum = acc_q + sample_ext;
      cnt_sum = cnt_q + CNT_W'(1);
    end
    target     = CNT_W'(1) << r_use;
    block_done = (cnt_sum == target);
`ifdef ADC_DECIM_ROUND_EN
    if (r_use == 4'd0) begin
      rounded = acc_sum;
    end else begin
      rounded = acc_sum + (ACC_W'(1) << (r_use - 4'd1));
    end
`else
    rounded = acc_sum;
`endif
    shifted = rounded >>> r_use;
    result  = {{(ADC_AXIS_WIDTH-DATA_WIDTH){shifted[DATA_WIDTH-1]}},
               shifted[DATA_WIDTH-1:0]};
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    r_cur_d  = r_cur_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    blocks_d = blocks_q;

    if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    // Flush wins over a same-cycle accept; the output register is left alone.
    if (flush) begin
      state_d = EMPTY;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      r_cur_d = r_use;
      if (block_done) begin
        state_d  = EMPTY;
        acc_d    = '0;
        cnt_d    = '0;
        tvalid_d = 1'b1;
        tdata_d  = result;
        blocks_d = blocks_q + 16'd1;
      end else begin
        state_d = ACCUM;
        acc_d   = acc_sum;
        cnt_d   = cnt_sum;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= EMPTY;
      acc_q    <= '0;
      cnt_q    <= '0;
      r_cur_q  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      blocks_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      r_cur_q  <= r_cur_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      blocks_q <= blocks_d;
    end
  end

endmodule
